// File: rtl/vga_filter_pkg.sv
// Shared definitions for the VGA video filters: mode encoding, default
// Rec.709 luma weights and the fixed pixel-pipeline latency.
package vga_filter_pkg;

  typedef enum logic [1:0] {
    MODE_COLOUR = 2'd0,
    MODE_GREEN  = 2'd1,
    MODE_AMBER  = 2'd2,
    MODE_WHITE  = 2'd3
  } mode_e;

  localparam int MODE_W  = 2;

  localparam int DEF_W_R = 54;
  localparam int DEF_W_G = 183;
  localparam int DEF_W_B = 19;

  // Input-to-output delay of every filter in this family, in pixel clocks.
  localparam int LATENCY = 3;

endpackage

// File: rtl/vga_luma_filter_if.sv
// Parallel VGA pixel bus: colour components plus syncs and display enable.
// The producer of the bus uses the master modport, the consumer the slave.
interface vga_luma_filter_if #(
  parameter int CW = 6
);
  logic [CW-1:0] r;
  logic [CW-1:0] g;
  logic [CW-1:0] b;
  logic          hsync;
  logic          vsync;
  logic          de;

  modport master (output r, g, b, hsync, vsync, de);
  modport slave  (input  r, g, b, hsync, vsync, de);
endinterface

// File: rtl/vga_sync_delay.sv
// N-stage shift register for {hsync, vsync, de, mode}; resets every stage to
// inactive syncs, de low and mode 0 so a flushed pipeline emits blanking.
module vga_sync_delay #(
  parameter int N      = 2,
  parameter int MW     = 2,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          de_in,
  input  logic [MW-1:0] mode_in,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          de_out,
  output logic [MW-1:0] mode_out
);
  localparam int            BW      = MW + 3;
  localparam logic [BW-1:0] RST_VAL = {~HS_POL, ~VS_POL, 1'b0, {MW{1'b0}}};

  logic [BW-1:0] chain [N+1];

  assign chain[0] = {hsync_in, vsync_in, de_in, mode_in};

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      logic [BW-1:0] tap_d;
      logic [BW-1:0] tap_q;

      always_comb begin
        tap_d = chain[gi];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          tap_q <= RST_VAL;
        end else begin
          tap_q <= tap_d;
        end
      end

      assign chain[gi+1] = tap_q;
    end
  endgenerate

  assign {hsync_out, vsync_out, de_out, mode_out} = chain[N];

endmodule

// File: rtl/vga_luma_filter.sv
// Three-stage Rec.709 luma / tint filter for the VGA output path; modes switch
// only on a vsync assertion edge. Optional scanline dimming under SCANLINE_EN.
module vga_luma_filter
  import vga_filter_pkg::*;
#(
  parameter int CW     = 6,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int W_R    = DEF_W_R,
  parameter int W_G    = DEF_W_G,
  parameter int W_B    = DEF_W_B
) (
  input  logic                clk_vga,
  input  logic                rst,
  vga_luma_filter_if.slave    vid_in,
  vga_luma_filter_if.master   vid_out,
  input  logic [MODE_W-1:0]   mode_sel,
  input  logic                scanline_on,
  output logic [MODE_W-1:0]   mode_active
);
  localparam int            PW    = CW + 8;
  localparam int            SW    = CW + 9;
  localparam logic [CW-1:0] MAX_C = {CW{1'b1}};

  if (W_R + W_G + W_B != 256) begin : g_bad_weights
    $error("vga_luma_filter: W_R + W_G + W_B must equal 256");
  end

  // Mode latch on the vsync assertion edge
  logic              vs_prev_q, vs_prev_d;
  logic              vs_edge;
  logic [MODE_W-1:0] mode_q, mode_d;

  always_comb begin
    vs_edge   = (vid_in.vsync == VS_POL) && (vs_prev_q != VS_POL);
    vs_prev_d = vid_in.vsync;
    mode_d    = vs_edge ? mode_sel : mode_q;
  end

  // Stage 1: raw colour and weighted products
  logic [CW-1:0] r1_q, g1_q, b1_q, r1_d, g1_d, b1_d;
  logic [PW-1:0] pr_q, pg_q, pb_q, pr_d, pg_d, pb_d;

  always_comb begin
    r1_d = vid_in.r;
    g1_d = vid_in.g;
    b1_d = vid_in.b;
    pr_d = PW'(vid_in.r) * PW'(W_R);
    pg_d = PW'(vid_in.g) * PW'(W_G);
    pb_d = PW'(vid_in.b) * PW'(W_B);
  end

  // Stage 2: luma sum, truncate and saturate
  logic [CW-1:0] r2_q, g2_q, b2_q, r2_d, g2_d, b2_d;
  logic [CW-1:0] luma2_q, luma2_d;
  logic [SW-1:0] sum;
  logic [SW-1:0] luma_wide;

  always_comb begin
    r2_d      = r1_q;
    g2_d      = g1_q;
    b2_d      = b1_q;
    sum       = SW'(pr_q) + SW'(pg_q) + SW'(pb_q);
    luma_wide = sum >> 8;
    luma2_d   = (luma_wide > SW'(MAX_C)) ? MAX_C : luma_wide[CW-1:0];
  end

  // Syncs, de and per-pixel mode ride alongside stages 1 and 2
  logic              hs2, vs2, de2;
  logic [MODE_W-1:0] mode2;

  vga_sync_delay #(
    .N      (LATENCY - 1),
    .MW     (MODE_W),
    .HS_POL (HS_POL),
    .VS_POL (VS_POL)
  ) u_sync_delay (
    .clk       (clk_vga),
    .rst       (rst),
    .hsync_in  (vid_in.hsync),
    .vsync_in  (vid_in.vsync),
    .de_in     (vid_in.de),
    .mode_in   (mode_d),
    .hsync_out (hs2),
    .vsync_out (vs2),
    .de_out    (de2),
    .mode_out  (mode2)
  );

`ifdef SCANLINE_EN
  // Line parity follows the pixel so in-flight pixels keep their line's value
  logic hs_prev_q, hs_prev_d;
  logic parity_q, parity_d;
  logic par1_q, par1_d;
  logic par2_q, par2_d;

  always_comb begin
    hs_prev_d = vid_in.hsync;
    parity_d  = parity_q;
    if (vs_edge) begin
      parity_d = 1'b0;
    end else if ((vid_in.hsync == HS_POL) && (hs_prev_q != HS_POL)) begin
      parity_d = ~parity_q;
    end
    par1_d = parity_d;
    par2_d = par1_q;
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      hs_prev_q <= ~HS_POL;
      parity_q  <= 1'b0;
      par1_q    <= 1'b0;
      par2_q    <= 1'b0;
    end else begin
      hs_prev_q <= hs_prev_d;
      parity_q  <= parity_d;
      par1_q    <= par1_d;
      par2_q    <= par2_d;
    end
  end
`else
  logic unused_scanline;
  assign unused_scanline = scanline_on;
`endif

  // Stage 3: tint, optional scanline dimming, blanking
  logic [CW-1:0] r3_q, g3_q, b3_q, r3_d, g3_d, b3_d;
  logic          hs3_q, vs3_q, de3_q, hs3_d, vs3_d, de3_d;
  logic [CW-1:0] rt, gt, bt;

  always_comb begin
    rt = r2_q;
    gt = g2_q;
    bt = b2_q;
    case (mode_e'(mode2))
      MODE_GREEN: begin
        rt = '0;
        gt = luma2_q;
        bt = '0;
      end
      MODE_AMBER: begin
        rt = luma2_q;
        gt = luma2_q >> 1;
        bt = '0;
      end
      MODE_WHITE: begin
        rt = luma2_q;
        gt = luma2_q;
        bt = luma2_q;
      end
      default: ;
    endcase
`ifdef SCANLINE_EN
    if (scanline_on && par2_q) begin
      rt = rt >> 1;
      gt = gt >> 1;
      bt = bt >> 1;
    end
`endif
    if (!de2) begin
      rt = '0;
      gt = '0;
      bt = '0;
    end
    r3_d  = rt;
    g3_d  = gt;
    b3_d  = bt;
    hs3_d = hs2;
    vs3_d = vs2;
    de3_d = de2;
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      vs_prev_q <= ~VS_POL;
      mode_q    <= MODE_COLOUR;
      r1_q      <= '0;
      g1_q      <= '0;
      b1_q      <= '0;
      pr_q      <= '0;
      pg_q      <= '0;
      pb_q      <= '0;
      r2_q      <= '0;
      g2_q      <= '0;
      b2_q      <= '0;
      luma2_q   <= '0;
      r3_q      <= '0;
      g3_q      <= '0;
      b3_q      <= '0;
      hs3_q     <= ~HS_POL;
      vs3_q     <= ~VS_POL;
      de3_q     <= 1'b0;
    end else begin
      vs_prev_q <= vs_prev_d;
      mode_q    <= mode_d;
      r1_q      <= r1_d;
      g1_q      <= g1_d;
      b1_q      <= b1_d;
      pr_q      <= pr_d;
      pg_q      <= pg_d;
      pb_q      <= pb_d;
      r2_q      <= r2_d;
      g2_q      <= g2_d;
      b2_q      <= b2_d;
      luma2_q   <= luma2_d;
      r3_q      <= r3_d;
      g3_q      <= g3_d;
      b3_q      <= b3_d;
      hs3_q     <= hs3_d;
      vs3_q     <= vs3_d;
      de3_q     <= de3_d;
    end
  end

  assign vid_out.r     = r3_q;
  assign vid_out.g     = g3_q;
  assign vid_out.b     = b3_q;
  assign vid_out.hsync = hs3_q;
  assign vid_out.vsync = vs3_q;
  assign vid_out.de    = de3_q;
  assign mode_active   = mode_q;

endmodule

// File: tb/tb_vga_luma_filter.sv
// Scoreboard bench for vga_luma_filter: two instances (active-low and
// active-high syncs) share stimulus; a monitor checks each pixel on its due cycle.
`timescale 1ns/1ps
module tb_vga_luma_filter;
  import vga_filter_pkg::*;

  localparam int CW = 6;

  logic       clk_vga = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode_sel = 2'd0;
  logic       scanline_on = 1'b0;
  logic [1:0] mode_act_a;
  logic [1:0] mode_act_b;

  always #5 clk_vga = ~clk_vga;

  vga_luma_filter_if #(.CW(CW)) vin_a ();
  vga_luma_filter_if #(.CW(CW)) vout_a ();
  vga_luma_filter_if #(.CW(CW)) vin_b ();
  vga_luma_filter_if #(.CW(CW)) vout_b ();

  vga_luma_filter #(.CW(CW), .HS_POL(1'b0), .VS_POL(1'b0)) dut_a (
    .clk_vga     (clk_vga),
    .rst         (rst),
    .vid_in      (vin_a),
    .vid_out     (vout_a),
    .mode_sel    (mode_sel),
    .scanline_on (scanline_on),
    .mode_active (mode_act_a)
  );

  vga_luma_filter #(.CW(CW), .HS_POL(1'b1), .VS_POL(1'b1)) dut_b (
    .clk_vga     (clk_vga),
    .rst         (rst),
    .vid_in      (vin_b),
    .vid_out     (vout_b),
    .mode_sel    (mode_sel),
    .scanline_on (scanline_on),
    .mode_active (mode_act_b)
  );

  // hs/vs in an entry are "asserted" flags; each DUT maps them to its polarity
  typedef struct {
    int            due;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic          hs;
    logic          vs;
    logic          de;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk_vga) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk_vga) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missed_pixel: due %0d, now %0d", e.due, cyc);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk($sformatf("pixA@%0d {r,g,b,hs,vs,de}", cyc),
          {vout_a.r, vout_a.g, vout_a.b, vout_a.hsync, vout_a.vsync, vout_a.de},
          {e.r, e.g, e.b, ~e.hs, ~e.vs, e.de});
      chk($sformatf("pixB@%0d {r,g,b,hs,vs,de}", cyc),
          {vout_b.r, vout_b.g, vout_b.b, vout_b.hsync, vout_b.vsync, vout_b.de},
          {e.r, e.g, e.b, e.hs, e.vs, e.de});
    end
  end

  task automatic drive(input logic [CW-1:0] r, input logic [CW-1:0] g, input logic [CW-1:0] b,
                       input logic de, input logic hs, input logic vs,
                       input logic [CW-1:0] er, input logic [CW-1:0] eg, input logic [CW-1:0] eb);
    exp_t e;
    @(posedge clk_vga);
    #1;
    rst = 1'b0;
    vin_a.r = r;  vin_a.g = g;  vin_a.b = b;  vin_a.de = de;
    vin_a.hsync = ~hs;  vin_a.vsync = ~vs;
    vin_b.r = r;  vin_b.g = g;  vin_b.b = b;  vin_b.de = de;
    vin_b.hsync = hs;   vin_b.vsync = vs;
    e.due = cyc + LATENCY;
    e.r = er;  e.g = eg;  e.b = eb;
    e.hs = hs; e.vs = vs; e.de = de;
    sb.push_back(e);
  endtask

  task automatic px(input logic [CW-1:0] r, input logic [CW-1:0] g, input logic [CW-1:0] b,
                    input logic [CW-1:0] er, input logic [CW-1:0] eg, input logic [CW-1:0] eb);
    drive(r, g, b, 1'b1, 1'b0, 1'b0, er, eg, eb);
  endtask

  task automatic blank(input logic hs, input logic vs);
    drive(6'd63, 6'd63, 6'd63, 1'b0, hs, vs, 6'd0, 6'd0, 6'd0);
  endtask

  task automatic frame_edge(input logic [1:0] m);
    mode_sel = m;
    blank(1'b0, 1'b1);
    blank(1'b0, 1'b1);
    blank(1'b0, 1'b0);
  endtask

  task automatic check_mode(input string name, input logic [1:0] req);
    @(negedge clk_vga);
    chk({name, "_A"}, {30'd0, mode_act_a}, {30'd0, req});
    chk({name, "_B"}, {30'd0, mode_act_b}, {30'd0, req});
  endtask

  // Everything still in flight, plus this cycle's pixel, leaves as reset values
  task automatic do_reset();
    exp_t e;
    @(posedge clk_vga);
    #1;
    rst = 1'b1;
    foreach (sb[i]) begin
      if (sb[i].due > cyc) begin
        sb[i].r = '0;  sb[i].g = '0;  sb[i].b = '0;
        sb[i].hs = 1'b0; sb[i].vs = 1'b0; sb[i].de = 1'b0;
      end
    end
    e.due = cyc + LATENCY;
    e.r = '0;  e.g = '0;  e.b = '0;
    e.hs = 1'b0; e.vs = 1'b0; e.de = 1'b0;
    sb.push_back(e);
  endtask

  initial begin
    vin_a.r = '0; vin_a.g = '0; vin_a.b = '0; vin_a.de = 1'b0;
    vin_a.hsync = 1'b1; vin_a.vsync = 1'b1;
    vin_b.r = '0; vin_b.g = '0; vin_b.b = '0; vin_b.de = 1'b0;
    vin_b.hsync = 1'b0; vin_b.vsync = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk_vga);
    @(negedge clk_vga);
    chk("rst_rgb_A", {26'd0, vout_a.r, vout_a.g, vout_a.b}, 32'd0);
    chk("rst_syncs_A", {29'd0, vout_a.hsync, vout_a.vsync, vout_a.de}, 32'b110);
    chk("rst_syncs_B", {29'd0, vout_b.hsync, vout_b.vsync, vout_b.de}, 32'b000);
    chk("rst_mode_A", {30'd0, mode_act_a}, 32'd0);

    // White: mode latched on the vsync edge, visible the cycle after
    mode_sel = 2'd3;
    blank(1'b0, 1'b0);
    blank(1'b0, 1'b1);
    check_mode("pre_edge", 2'd0);
    blank(1'b0, 1'b1);
    check_mode("post_edge", 2'd3);
    blank(1'b0, 1'b0);
    px(6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63);

    // Green
    frame_edge(2'd1);
    px(6'd63, 6'd0, 6'd0, 6'd0, 6'd13, 6'd0);
    px(6'd0, 6'd63, 6'd0, 6'd0, 6'd45, 6'd0);

    // Amber
    frame_edge(2'd2);
    px(6'd0, 6'd0, 6'd63, 6'd4, 6'd2, 6'd0);
    px(6'd63, 6'd63, 6'd63, 6'd63, 6'd31, 6'd0);

    // Colour pass-through
    frame_edge(2'd0);
    px(6'd12, 6'd34, 6'd56, 6'd12, 6'd34, 6'd56);
    check_mode("colour", 2'd0);

    // Mid-frame request for white is held until the next vsync edge
    mode_sel = 2'd3;
    px(6'd12, 6'd34, 6'd56, 6'd12, 6'd34, 6'd56);
    blank(1'b1, 1'b0);
    blank(1'b0, 1'b0);
    px(6'd63, 6'd0, 6'd0, 6'd63, 6'd0, 6'd0);
    blank(1'b0, 1'b1);
    check_mode("mid_pre_edge", 2'd0);
    blank(1'b0, 1'b1);
    check_mode("mid_post_edge", 2'd3);
    blank(1'b0, 1'b0);
    px(6'd63, 6'd0, 6'd0, 6'd13, 6'd13, 6'd13);
    px(6'd12, 6'd34, 6'd56, 6'd30, 6'd30, 6'd30);

    // de low blanks in every mode; hsync pulses ride the same delay
    for (int m = 0; m < 4; m++) begin
      frame_edge(m[1:0]);
      drive(6'd63, 6'd63, 6'd63, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0);
      blank(1'b0, 1'b0);
    end

    // mode_sel change without a vsync edge is ignored
    mode_sel = 2'd1;
    px(6'd63, 6'd0, 6'd0, 6'd13, 6'd13, 6'd13);
    check_mode("ignored_sel", 2'd3);

    // Reset mid-line in amber
    frame_edge(2'd2);
    px(6'd0, 6'd0, 6'd63, 6'd4, 6'd2, 6'd0);
    px(6'd63, 6'd63, 6'd63, 6'd63, 6'd31, 6'd0);
    do_reset();
    px(6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63);
    check_mode("after_rst", 2'd0);
    px(6'd12, 6'd34, 6'd56, 6'd12, 6'd34, 6'd56);
    frame_edge(2'd2);
    check_mode("relatch", 2'd2);
    px(6'd0, 6'd0, 6'd63, 6'd4, 6'd2, 6'd0);

`ifdef SCANLINE_EN
    scanline_on = 1'b1;
    frame_edge(2'd3);
    px(6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63);
    blank(1'b1, 1'b0);
    blank(1'b0, 1'b0);
    px(6'd63, 6'd63, 6'd63, 6'd31, 6'd31, 6'd31);
    blank(1'b1, 1'b0);
    blank(1'b0, 1'b0);
    px(6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63);
    blank(1'b0, 1'b0);
`endif

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk_vga);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d pixels left, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
